// File: rtl/alu_issue_if.sv
// Handshake/operand bundle between the ID stage, the ALU issue stage and the ALU.
// master = environment side (drives ops, consumes results); slave = issue stage.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [WIDTH-1:0] exmem_result;
  logic [WIDTH-1:0] memwb_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             a_invert;
  logic             b_negate;
  logic [1:0]       operation;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src,
           fwd_a_sel, fwd_b_sel, exmem_result, memwb_result, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, a_invert, b_negate, operation, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src,
           fwd_a_sel, fwd_b_sel, exmem_result, memwb_result, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, a_invert, b_negate, operation, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding, ALU control decode and a 2-entry skid buffer.
// Optional ISSUE_STATS_EN adds issue/stall/illegal counters.
module alu_issue_stage #(
  parameter int WIDTH  = 32,
  parameter int STAT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] issue_count,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] illegal_count
`endif
);

  // ctl layout: {a_invert, b_negate, operation[1:0], illegal}
  logic [WIDTH-1:0] a_q   [2];
  logic [WIDTH-1:0] b_q   [2];
  logic [4:0]       ctl_q [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       dec_ctl;

  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.alu_a     = a_q[rd_ptr];
  assign bus.alu_b     = b_q[rd_ptr];
  assign bus.a_invert  = ctl_q[rd_ptr][4];
  assign bus.b_negate  = ctl_q[rd_ptr][3];
  assign bus.operation = ctl_q[rd_ptr][2:1];
  assign bus.illegal   = ctl_q[rd_ptr][0];

  always_comb begin
    fwd_a = bus.rs_data;
    fwd_b = bus.rt_data;
    case (bus.fwd_a_sel)
      2'b01:   fwd_a = bus.exmem_result;
      2'b10:   fwd_a = bus.memwb_result;
      default: fwd_a = bus.rs_data;
    endcase
    case (bus.fwd_b_sel)
      2'b01:   fwd_b = bus.exmem_result;
      2'b10:   fwd_b = bus.memwb_result;
      default: fwd_b = bus.rt_data;
    endcase
    op_b = bus.alu_src ? bus.imm : fwd_b;
  end

  // Undecodable ops still issue as an add, flagged illegal.
  always_comb begin
    dec_ctl = 5'b00101;
    case (bus.alu_op)
      2'b00: dec_ctl = 5'b00100;
      2'b01: dec_ctl = 5'b01100;
      2'b10: begin
        case (bus.funct)
          6'b100000, 6'b100001: dec_ctl = 5'b00100;
          6'b100010, 6'b100011: dec_ctl = 5'b01100;
          6'b100100:            dec_ctl = 5'b00000;
          6'b100101:            dec_ctl = 5'b00010;
          6'b100111:            dec_ctl = 5'b11000;
          6'b101010:            dec_ctl = 5'b01110;
          default:              dec_ctl = 5'b00101;
        endcase
      end
      default: dec_ctl = 5'b00101;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        ctl_q[i] <= '0;
      end
    end else if (bus.flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        a_q[wr_ptr]   <= fwd_a;
        b_q[wr_ptr]   <= op_b;
        ctl_q[wr_ptr] <= dec_ctl;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  // A pop squashed by flush is not an issue; stalls are counted regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count   <= '0;
      stall_count   <= '0;
      illegal_count <= '0;
    end else begin
      if (pop && !bus.flush) begin
        issue_count <= issue_count + STAT_W'(1);
        if (bus.illegal) begin
          illegal_count <= illegal_count + STAT_W'(1);
        end
      end
      if (bus.in_valid && !bus.in_ready) begin
        stall_count <= stall_count + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard monitor plus per-scenario tasks.
// Honours ISSUE_STATS_EN when defined.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       ctl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_if #(.WIDTH(WIDTH)) bus();

`ifdef ISSUE_STATS_EN
  logic [31:0] issue_count, stall_count, illegal_count;
`endif

  alu_issue_stage #(.WIDTH(WIDTH), .STAT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ISSUE_STATS_EN
    ,
    .issue_count   (issue_count),
    .stall_count   (stall_count),
    .illegal_count (illegal_count)
`endif
  );

  exp_t q[$];
  exp_t mon_head;
  exp_t mon_new;
  logic mon_can_push;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  logic [5:0] funct_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h21, 6'h23};
  logic [4:0] ctl_tab   [9] = '{5'b00100, 5'b01100, 5'b00000, 5'b00010, 5'b11000,
                                5'b01110, 5'b00101, 5'b00100, 5'b01100};

  function automatic logic [4:0] model_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b00100;
    if (op == 2'b01) return 5'b01100;
    if (op == 2'b11) return 5'b00101;
    if (f == 6'h20 || f == 6'h21) return 5'b00100;
    if (f == 6'h22 || f == 6'h23) return 5'b01100;
    if (f == 6'h24) return 5'b00000;
    if (f == 6'h25) return 5'b00010;
    if (f == 6'h27) return 5'b11000;
    if (f == 6'h2a) return 5'b01110;
    return 5'b00101;
  endfunction

  function automatic logic [WIDTH-1:0] model_fwd(input logic [1:0] sel, input logic [WIDTH-1:0] reg_v,
                                                 input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] wb);
    if (sel == 2'b01) return ex;
    if (sel == 2'b10) return wb;
    return reg_v;
  endfunction

  // Scoreboard: decide the upcoming edge's handshakes from the model occupancy.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      q.delete();
    end else begin
      n_checks++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL out_valid: got %b exp %b", bus.out_valid, q.size() != 0);
      end
      n_checks++;
      if (bus.in_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL in_ready: got %b exp %b", bus.in_ready, q.size() < 2);
      end
      if (q.size() != 0) begin
        mon_head = q[0];
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.a_invert, bus.b_negate, bus.operation, bus.illegal}
            !== {mon_head.a, mon_head.b, mon_head.ctl}) begin
          n_fail++;
          $display("FAIL head: got a=%h b=%h ctl=%b exp a=%h b=%h ctl=%b", bus.alu_a, bus.alu_b,
                   {bus.a_invert, bus.b_negate, bus.operation, bus.illegal},
                   mon_head.a, mon_head.b, mon_head.ctl);
        end
      end
      if (bus.flush === 1'b1) begin
        q.delete();
      end else begin
        mon_can_push = (q.size() < 2);
        if (q.size() != 0 && bus.out_ready === 1'b1) begin
          mon_head = q.pop_front();
          n_pops++;
        end
        if (bus.in_valid === 1'b1 && mon_can_push) begin
          mon_new.a   = model_fwd(bus.fwd_a_sel, bus.rs_data, bus.exmem_result, bus.memwb_result);
          mon_new.b   = bus.alu_src ? bus.imm
                                    : model_fwd(bus.fwd_b_sel, bus.rt_data, bus.exmem_result, bus.memwb_result);
          mon_new.ctl = model_ctl(bus.alu_op, bus.funct);
          q.push_back(mon_new);
        end
      end
    end
  end

  task automatic set_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] im, input logic src,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] ex, input logic [31:0] wb);
    bus.alu_op = op; bus.funct = f; bus.rs_data = rs; bus.rt_data = rt; bus.imm = im;
    bus.alu_src = src; bus.fwd_a_sel = fa; bus.fwd_b_sel = fb;
    bus.exmem_result = ex; bus.memwb_result = wb; bus.in_valid = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < max_cycles && q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d ops left exp 0", q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    set_op(2'b00, 6'h0, '0, '0, '0, 1'b0, 2'b00, 2'b00, '0, '0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b, bus.a_invert, bus.b_negate,
         bus.operation, bus.illegal} !== {1'b0, 1'b1, 64'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b a=%h b=%h ctl=%b exp v=0 r=1 zeros", bus.out_valid,
               bus.in_ready, bus.alu_a, bus.alu_b, {bus.a_invert, bus.b_negate, bus.operation, bus.illegal});
    end
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [4:0] exp_ctl;
      @(posedge clk); #1;
      if (i < 9) begin
        set_op(2'b10, funct_tab[i], $urandom, $urandom, $urandom, 1'b0, 2'b00, 2'b00, $urandom, $urandom);
        exp_ctl = ctl_tab[i];
      end else if (i == 9) begin
        set_op(2'b00, 6'h24, $urandom, $urandom, $urandom, 1'b1, 2'b00, 2'b00, $urandom, $urandom);
        exp_ctl = 5'b00100;
      end else if (i == 10) begin
        set_op(2'b01, 6'h25, $urandom, $urandom, $urandom, 1'b0, 2'b00, 2'b00, $urandom, $urandom);
        exp_ctl = 5'b01100;
      end else begin
        set_op(2'b11, 6'h20, $urandom, $urandom, $urandom, 1'b0, 2'b00, 2'b00, $urandom, $urandom);
        exp_ctl = 5'b00101;
      end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.a_invert, bus.b_negate, bus.operation, bus.illegal} !== {1'b1, exp_ctl}) begin
        n_fail++;
        $display("FAIL decode_%0d: got v=%b ctl=%b exp v=1 ctl=%b", i, bus.out_valid,
                 {bus.a_invert, bus.b_negate, bus.operation, bus.illegal}, exp_ctl);
      end
    end
    drain(4);
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a [3] = '{32'd9, 32'd7, 32'd5};
    logic [31:0] exp_b [3] = '{32'd7, 32'hFFFF_FFFC, 32'd3};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0:       set_op(2'b00, 6'h0, 32'd5, 32'd3, 32'h1234, 1'b0, 2'b01, 2'b10, 32'd9, 32'd7);
        1:       set_op(2'b00, 6'h0, 32'd5, 32'd3, 32'hFFFF_FFFC, 1'b1, 2'b10, 2'b01, 32'd9, 32'd7);
        default: set_op(2'b00, 6'h0, 32'd5, 32'd3, 32'h1234, 1'b0, 2'b11, 2'b11, 32'd9, 32'd7);
      endcase
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.alu_a !== exp_a[i] || bus.alu_b !== exp_b[i]) begin
        n_fail++;
        $display("FAIL fwd_%0d: got a=%h b=%h exp a=%h b=%h", i, bus.alu_a, bus.alu_b, exp_a[i], exp_b[i]);
      end
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'hAAAA_0001, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b01, 6'h0, 32'hBBBB_0002, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b10, 6'h25, 32'hCCCC_0003, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.alu_a !== 32'hAAAA_0001 || bus.operation !== 2'b10) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got r=%b a=%h op=%b exp r=0 a=aaaa0001 op=10", i,
                 bus.in_ready, bus.alu_a, bus.operation);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.alu_a !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL bp_first: got %h exp aaaa0001", bus.alu_a);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alu_a !== 32'hBBBB_0002 || bus.b_negate !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got a=%h bneg=%b exp a=bbbb0002 bneg=1", bus.alu_a, bus.b_negate);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    int pops0;
`ifdef ISSUE_STATS_EN
    logic [31:0] iss0;
    iss0 = issue_count;
`endif
    pops0 = n_pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_op(2'($urandom_range(0, 3)), funct_tab[i % 9], $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stream_%0d: got v=%b r=%b exp v=1 r=1", i, bus.out_valid, bus.in_ready);
        end
      end
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (n_pops - pops0 != 10 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: got pops=%0d v=%b exp pops=10 v=0", n_pops - pops0, bus.out_valid);
    end
`ifdef ISSUE_STATS_EN
    n_checks++;
    if (issue_count - iss0 !== 32'd10) begin
      n_fail++;
      $display("FAIL b2b_issue_count: got %0d exp 10", issue_count - iss0);
    end
`endif
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'h1111_0001, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'h1111_0002, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'hDEAD_0003, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'h2222_0001, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'hDEAD_0004, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_one: got v=%b exp v=0", bus.out_valid);
    end
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'h3333_0005, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'h3333_0005) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b a=%h exp v=1 a=33330005", bus.out_valid, bus.alu_a);
    end
    drain(4);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    @(posedge clk); #1 set_op(2'b10, 6'h27, 32'h4444_0001, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b11, 6'h0, 32'h4444_0002, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1 set_op(2'b00, 6'h0, 32'h4444_0003, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    reset = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b, bus.a_invert, bus.b_negate,
         bus.operation, bus.illegal} !== {1'b0, 1'b1, 64'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b r=%b a=%h b=%h ctl=%b exp v=0 r=1 zeros", bus.out_valid,
               bus.in_ready, bus.alu_a, bus.alu_b, {bus.a_invert, bus.b_negate, bus.operation, bus.illegal});
    end
`ifdef ISSUE_STATS_EN
    n_checks++;
    if ({issue_count, stall_count, illegal_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d %0d %0d exp 0 0 0", issue_count, stall_count, illegal_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forwarding();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test exp finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage directly upstream of the 32-bit ALU.
- Captures decoded instruction fields and resolves the A/B operands, including forwarding and the immediate select.
- Translates ALUOp/funct into the ALU's A_invert, B_negate and Operation controls.
- Holds up to two issued ops in a skid buffer with valid/ready handshakes on both sides; the ALU stays purely combinational downstream.

Parameters:
WIDTH, 32, operand/datapath width.
STAT_W, 32, width of statistic counters (used only with ISSUE_STATS_EN).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream (ID) presents an op
in_ready  output  1  stage can accept an op this cycle
alu_op  input  2  00=add (lw/sw/addi), 01=sub (beq), 10=R-type (use funct), 11=reserved
funct  input  6  R-type function field
rs_data  input  WIDTH  register-file rs value
rt_data  input  WIDTH  register-file rt value
imm  input  WIDTH  sign-extended immediate
alu_src  input  1  1: B operand = imm
fwd_a_sel  input  2  00=rs_data, 01=exmem_result, 10=memwb_result, 11=rs_data
fwd_b_sel  input  2  same encoding, applied to rt_data before the alu_src mux
exmem_result  input  WIDTH  EX/MEM forward value
memwb_result  input  WIDTH  MEM/WB forward value
flush  input  1  discard all buffered ops (branch/exception)
out_valid  output  1  head op is valid for the ALU
out_ready  input  1  downstream consumes the head op this cycle
alu_a  output  WIDTH  ALU A operand
alu_b  output  WIDTH  ALU B operand
a_invert  output  1  ALU A_invert
b_negate  output  1  ALU B_negate (B invert + carry-in)
operation  output  2  ALU Operation: 00 AND, 01 OR, 10 SUM, 11 Less
illegal  output  1  head op carried an undecodable alu_op/funct

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high, named reset.
- Storage: 2-entry FIFO (skid buffer). Each entry holds {alu_a, alu_b, a_invert, b_negate, operation, illegal}.
- Handshakes:
  - in_ready = (count < 2), derived from registered count only.
  - Push on in_valid && in_ready.
  - Pop on out_valid && out_ready.
  - out_valid = (count > 0). Outputs always show the head entry.
- Operand resolution happens at push time:
  - A = forward mux(fwd_a_sel).
  - B = alu_src ? imm : forward mux(fwd_b_sel).
  - Forward values are sampled in the push cycle only and are not re-evaluated while buffered.
- Decode, as {a_invert, b_negate, operation}:
  - alu_op 00 -> 0,0,10 (add)
  - alu_op 01 -> 0,1,10 (sub)
  - alu_op 10 with funct 100000/100001 -> add; 100010/100011 -> sub; 100100 -> 0,0,00 (AND); 100101 -> 0,0,01 (OR); 100111 -> 1,1,00 (NOR); 101010 -> 0,1,11 (SLT)
  - any other funct, or alu_op 11 -> controls 0,0,10 and illegal=1. The op is still issued, never dropped.
- Latency: an op pushed in cycle N into an empty buffer appears on the outputs in cycle N+1. There is no combinational in->out path.
- Simultaneous push and pop:
  - count=1: count stays 1; the new op becomes head next cycle.
  - count=0: push only.
  - count=2: push impossible (in_ready=0).
- FIFO order is strict; wrap-around uses 1-bit read/write pointers.
- flush:
  - Next cycle count=0, out_valid=0, and pointers return to 0.
  - flush dominates a same-cycle push (the op is dropped) and a same-cycle pop.
  - in_ready returns to 1 the cycle after flush.
- Output hold: outputs stay stable while out_valid && !out_ready.
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1 the cycle after reset. Payload regs clear to 0, so alu_a, alu_b, a_invert, b_negate and illegal read 0 and operation reads 00. reset dominates flush and all handshakes.
- Reset mid-operation: all buffered ops are lost with no partial state.

Optional Feature:
ISSUE_STATS_EN
- Defined:
  - Adds outputs issue_count [STAT_W], stall_count [STAT_W], illegal_count [STAT_W].
  - issue_count increments on each pop.
  - stall_count increments each cycle in_valid && !in_ready.
  - illegal_count increments on each pop with illegal=1.
  - All counters wrap modulo 2^STAT_W, clear on reset, and are unaffected by flush.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Decode sweep:
  - alu_op=10 with funct 100000, 100010, 100100, 100101, 100111, 101010 -> {a_inv,b_neg,op} = 0,0,10 / 0,1,10 / 0,0,00 / 0,0,01 / 1,1,00 / 0,1,11.
  - funct 000000 -> illegal=1, op=10.
- Forwarding:
  - rs_data=5, exmem_result=9, memwb_result=7, fwd_a_sel=01 -> alu_a=9.
  - fwd_b_sel=10, alu_src=0 -> alu_b=7.
  - alu_src=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC.
- Backpressure:
  - out_ready=0, push ops X, Y -> in_ready=0 after 2 pushes; a third in_valid is stalled.
  - Raise out_ready -> X then Y in order, each held stable while stalled.
- Simultaneous push/pop at count=1, streamed 10 back-to-back ops with out_ready=1 -> one op issued per cycle after a 1-cycle latency, count constant at 1.
- Flush:
  - count=2 plus flush with a same-cycle push -> next cycle out_valid=0, in_ready=1.
  - The flushed op never appears.
- Reset mid-stream:
  - reset while count=2 -> next cycle all outputs 0, out_valid=0.
  - With ISSUE_STATS_EN, all counters read 0.
